pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the single-issue processor.
- Holds the architectural PC and computes the fall-through address PC+INSTR_BYTES.
- Computes the J/BEQ/BNE target as fall-through + (sign-extended offset << OFFSET_SHIFT) and applies it.
- Honours instruction-memory stalls, emits a one-cycle FLUSH after every redirect, and counts taken redirects for performance monitoring.

Parameters:
- PC_WIDTH, 32, width of PC and all address arithmetic.
- OFFSET_WIDTH, 8, width of the signed instruction offset field.
- OFFSET_SHIFT, 2, left shift applied to the sign-extended offset (word to byte).
- INSTR_BYTES, 4, fall-through increment.
- RESET_VECTOR, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of the taken-redirect counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  instruction/data memory busywait; 1 freezes PC and counter.
- JUMP  in  1  unconditional relative jump request.
- BRANCH  in  1  branch-if-equal request.
- BRANCH_NE  in  1  branch-if-not-equal request.
- ZERO  in  1  ALU zero flag for the current instruction.
- OFFSET  in  OFFSET_WIDTH  signed instruction offset, two's complement.
- PC  out  PC_WIDTH  current registered PC.
- PC_NEXT_SEQ  out  PC_WIDTH  combinational PC+INSTR_BYTES.
- TAKEN  out  1  combinational; 1 when the current instruction redirects.
- FLUSH  out  1  registered; high for exactly one cycle after an applied redirect.
- TAKEN_COUNT  out  CNT_WIDTH  registered count of applied redirects.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset values:
  - PC=RESET_VECTOR, FLUSH=0, TAKEN_COUNT=0.
  - RESET takes priority over STALL and all control inputs, including mid-stall with a redirect pending.
- Redirect select, priority JUMP > BRANCH > BRANCH_NE:
  - Taken if JUMP=1, or BRANCH=1 and ZERO=1, or BRANCH_NE=1 and ZERO=0.
  - Only the highest-priority asserted request is evaluated. Example: JUMP=0, BRANCH=1, BRANCH_NE=1, ZERO=0 is not taken, because BRANCH wins and its condition is false.
- Arithmetic:
  - target = PC_NEXT_SEQ + (sext(OFFSET to PC_WIDTH) << OFFSET_SHIFT).
  - All additions are modulo 2^PC_WIDTH; wrap-around is silent.
  - No misalignment check.
- State machine (2 states):
  - RUN: FLUSH=0.
  - REDIR: FLUSH=1.
  - RUN -> REDIR on an edge where a redirect is applied.
  - REDIR -> RUN on the next edge unless another redirect is applied, in which case it stays REDIR.
  - While STALL=1 the state holds. FLUSH therefore stays high across a stall that begins in REDIR, and is consumed on the first unstalled edge.
- Update at each rising edge with RESET=0:
  - STALL=1: PC, counter and state hold. TAKEN still reflects the inputs, but nothing is applied. The decoder keeps control inputs stable while stalled.
  - STALL=0 and TAKEN=1: PC<=target, TAKEN_COUNT<=TAKEN_COUNT+1, saturating at all-ones (no wrap).
  - STALL=0 and TAKEN=0: PC<=PC_NEXT_SEQ.
- Latency:
  - Redirect visible on PC one edge after the control is presented.
  - FLUSH is coincident with the first redirected PC.
- Input sampling: X on control inputs while STALL=1 is tolerated; control inputs are only sampled when STALL=0.

Decomposition:
- Shared package pc_pkg holds:
  - INSTR_BYTES and OFFSET_SHIFT defaults.
  - Default widths.
  - enum redir_sel_t {SEL_NONE, SEL_JUMP, SEL_BEQ, SEL_BNE}.
  - enum fsm_t {ST_RUN, ST_REDIR}.
- One natural sub-module: branch_target_adder.
  - Combinational, parametrised on PC_WIDTH, OFFSET_WIDTH and OFFSET_SHIFT.
  - Does sign-extend, shift and modulo add; reusable by the future pipelined fetch.

Test Plan (defaults unless stated):
1. Reset and sequencing: RESET=1 for 2 edges -> PC=0x0, FLUSH=0, TAKEN_COUNT=0. Release RESET -> PC steps 0x4, 0x8, 0xC on successive edges.
2. Backward jump: PC=0x10, JUMP=1, OFFSET=8'hFC -> next PC=0x14-0x10=0x04, FLUSH=1 for one cycle then 0, TAKEN_COUNT=1.
3. Conditional branches at PC=0x20, OFFSET=3:
   - BRANCH=1, ZERO=0 -> PC=0x24, TAKEN=0.
   - BRANCH=1, ZERO=1 -> PC=0x30.
   - BRANCH_NE=1, ZERO=0 -> PC=0x30.
   - JUMP=1, BRANCH=1, ZERO=0 -> PC=0x30 (JUMP priority).
4. Stall: PC=0x40, JUMP=1, OFFSET=8'h7F, STALL=1 for 3 edges -> PC stays 0x40, count unchanged, FLUSH=0. STALL=0 -> PC=0x44+0x1FC=0x240, count +1 exactly once.
5. Wrap and saturation:
   - RESET_VECTOR=0xFFFFFFFC, one edge -> PC=0x00000000.
   - CNT_WIDTH=2 with 5 consecutive jumps -> TAKEN_COUNT=3.
6. Reset mid-stall: STALL=1, JUMP=1 pending, assert RESET for one edge -> PC=RESET_VECTOR, FLUSH=0, TAKEN_COUNT=0, and no redirect applied afterwards until re-presented.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer and its helpers.
package pc_pkg;

  localparam int PC_WIDTH_DEF     = 32;
  localparam int OFFSET_WIDTH_DEF = 8;
  localparam int OFFSET_SHIFT_DEF = 2;
  localparam int INSTR_BYTES_DEF  = 4;
  localparam int CNT_WIDTH_DEF    = 16;

  // Which redirect request won the priority decode this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_JUMP = 2'd1,
    SEL_BEQ  = 2'd2,
    SEL_BNE  = 2'd3
  } redir_sel_t;

  // RUN: sequential fetch. REDIR: the PC just took a redirect, FLUSH is high.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } fsm_t;

endpackage

// File: rtl/branch_target_adder.sv
// Relative branch target: fall-through + (sign-extended offset << shift),
// modulo 2^PC_WIDTH. Purely combinational so a pipelined fetch can reuse it.
module branch_target_adder
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int OFFSET_SHIFT = OFFSET_SHIFT_DEF
) (
  input  logic [PC_WIDTH-1:0]     pc_next_seq,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0]     target
);

  logic [PC_WIDTH-1:0] offset_sext;
  logic [PC_WIDTH-1:0] offset_bytes;

  // Sign-extend, scale to bytes and add; carries out of PC_WIDTH are dropped.
  always_comb begin
    offset_sext  = {{(PC_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
    offset_bytes = offset_sext << OFFSET_SHIFT;
    target       = pc_next_seq + offset_bytes;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: holds the PC, computes fall-through and relative
// redirect targets, raises a one-cycle FLUSH after each applied redirect and
// counts applied redirects (saturating).
//
// Flow control: there is no valid/ready pair here. STALL=1 is a memory
// busywait that freezes every register (PC, counter, FSM); control inputs are
// only consumed on an edge where STALL=0, and the decoder holds them stable
// while stalled. TAKEN is combinational and may be observed at any time.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
  parameter int                  OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int                  OFFSET_SHIFT = OFFSET_SHIFT_DEF,
  parameter int                  INSTR_BYTES  = INSTR_BYTES_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    STALL,
  input  logic                    JUMP,
  input  logic                    BRANCH,
  input  logic                    BRANCH_NE,
  input  logic                    ZERO,
  input  logic [OFFSET_WIDTH-1:0] OFFSET,
  output logic [PC_WIDTH-1:0]     PC,
  output logic [PC_WIDTH-1:0]     PC_NEXT_SEQ,
  output logic                    TAKEN,
  output logic                    FLUSH,
  output logic [CNT_WIDTH-1:0]    TAKEN_COUNT,
  output fsm_t                    DBG_STATE
);

  redir_sel_t          sel;
  fsm_t                state;
  logic [PC_WIDTH-1:0] target;

  assign PC_NEXT_SEQ = PC + PC_WIDTH'(INSTR_BYTES);
  assign DBG_STATE   = state;

  branch_target_adder #(
    .PC_WIDTH     (PC_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .OFFSET_SHIFT (OFFSET_SHIFT)
  ) u_target (
    .pc_next_seq (PC_NEXT_SEQ),
    .offset      (OFFSET),
    .target      (target)
  );

  // Priority decode: only the highest asserted request has its condition evaluated.
  always_comb begin
    sel = SEL_NONE;
    if (JUMP)           sel = SEL_JUMP;
    else if (BRANCH)    sel = SEL_BEQ;
    else if (BRANCH_NE) sel = SEL_BNE;
  end

  // Resolve the winning request against the ALU zero flag.
  always_comb begin
    TAKEN = 1'b0;
    case (sel)
      SEL_JUMP: TAKEN = 1'b1;
      SEL_BEQ:  TAKEN = ZERO;
      SEL_BNE:  TAKEN = ~ZERO;
      default:  TAKEN = 1'b0;
    endcase
  end

  // PC, redirect FSM, FLUSH and counter; everything freezes while STALL is high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC          <= RESET_VECTOR;
      state       <= ST_RUN;
      FLUSH       <= 1'b0;
      TAKEN_COUNT <= '0;
    end else if (!STALL) begin
      if (TAKEN) begin
        PC    <= target;
        state <= ST_REDIR;
        FLUSH <= 1'b1;
        if (TAKEN_COUNT != '1) TAKEN_COUNT <= TAKEN_COUNT + CNT_WIDTH'(1);
      end else begin
        PC    <= PC_NEXT_SEQ;
        state <= ST_RUN;
        FLUSH <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a default-parameter instance driven
// against a reference model through an expected queue, plus a second instance
// with a wrapping reset vector and a 2-bit counter.
module tb_pc_sequencer;
  import pc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Default instance signals
  logic        RESET, STALL, JUMP, BRANCH, BRANCH_NE, ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC, PC_NEXT_SEQ;
  logic        TAKEN, FLUSH;
  logic [15:0] TAKEN_COUNT;
  fsm_t        DBG_STATE;

  // Wrap/saturation instance signals
  logic        r2, st2, j2, b2, bne2, z2;
  logic [7:0]  off2;
  logic [31:0] pc2, pcn2;
  logic        tk2, fl2;
  logic [1:0]  cnt2;
  fsm_t        dbg2;

  pc_sequencer dut (
    .CLK(clk), .RESET(RESET), .STALL(STALL), .JUMP(JUMP), .BRANCH(BRANCH),
    .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .OFFSET(OFFSET), .PC(PC),
    .PC_NEXT_SEQ(PC_NEXT_SEQ), .TAKEN(TAKEN), .FLUSH(FLUSH),
    .TAKEN_COUNT(TAKEN_COUNT), .DBG_STATE(DBG_STATE)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC), .CNT_WIDTH(2)) dut2 (
    .CLK(clk), .RESET(r2), .STALL(st2), .JUMP(j2), .BRANCH(b2),
    .BRANCH_NE(bne2), .ZERO(z2), .OFFSET(off2), .PC(pc2),
    .PC_NEXT_SEQ(pcn2), .TAKEN(tk2), .FLUSH(fl2),
    .TAKEN_COUNT(cnt2), .DBG_STATE(dbg2)
  );

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] m_pc    = 32'h0;
  logic        m_flush = 1'b0;
  logic [15:0] m_cnt   = 16'h0;
  logic [48:0] exp_q[$];

  function automatic logic model_taken(input logic j, b, bne, z);
    if (j)        return 1'b1;
    else if (b)   return z;
    else if (bne) return !z;
    else          return 1'b0;
  endfunction

  // ---------------- driver ----------------
  // One clock: drive at negedge, check combinational outputs, advance the
  // model, then compare registered outputs just after the rising edge.
  task automatic cycle(input string tag, input logic rst, st, j, b, bne, z,
                       input logic [7:0] off);
    logic        m_tk;
    logic [48:0] e;
    int          off_bytes;
    @(negedge clk);
    RESET = rst; STALL = st; JUMP = j; BRANCH = b; BRANCH_NE = bne; ZERO = z; OFFSET = off;
    #1;
    m_tk = model_taken(j, b, bne, z);
    check_val({tag, ".taken"}, 64'(TAKEN), 64'(m_tk));
    check_val({tag, ".pc_next_seq"}, 64'(PC_NEXT_SEQ), 64'(m_pc + 32'd4));
    if (rst) begin
      m_pc = 32'h0; m_flush = 1'b0; m_cnt = 16'h0;
    end else if (!st) begin
      if (m_tk) begin
        off_bytes = int'($signed(off)) * 4;
        m_pc      = m_pc + 32'd4 + 32'(off_bytes);
        m_flush   = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        m_pc    = m_pc + 32'd4;
        m_flush = 1'b0;
      end
    end
    exp_q.push_back({m_pc, m_flush, m_cnt});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, ".pc"},    64'(PC),          64'(e[48:17]));
      check_val({tag, ".flush"}, 64'(FLUSH),       64'(e[16]));
      check_val({tag, ".count"}, 64'(TAKEN_COUNT), 64'(e[15:0]));
      check_val({tag, ".state"}, 64'(DBG_STATE == ST_REDIR), 64'(e[16]));
    end
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Reset and step sequentially until PC reaches the given word-aligned address.
  task automatic goto_pc(input logic [31:0] a);
    cycle("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < int'(a >> 2); i++) idle("step");
  endtask

  // Drive the second instance for one edge and sample after it.
  task automatic cycle2(input logic rst, j);
    @(negedge clk);
    r2 = rst; st2 = 1'b0; j2 = j; b2 = 1'b0; bne2 = 1'b0; z2 = 1'b0; off2 = 8'h00;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1; STALL = 1'b0; JUMP = 1'b0; BRANCH = 1'b0; BRANCH_NE = 1'b0;
    ZERO = 1'b0; OFFSET = 8'h00;
    r2 = 1'b1; st2 = 1'b0; j2 = 1'b0; b2 = 1'b0; bne2 = 1'b0; z2 = 1'b0; off2 = 8'h00;

    // 1. reset for two edges, then sequential stepping
    cycle("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("reset1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_val("reset_pc", 64'(PC), 64'h0);
    idle("seq1"); check_val("seq_pc4", 64'(PC), 64'h4);
    idle("seq2"); check_val("seq_pc8", 64'(PC), 64'h8);
    idle("seq3"); check_val("seq_pcC", 64'(PC), 64'hC);
    idle("seq4");

    // 2. backward jump from 0x10
    cycle("bjump", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFC);
    check_val("bjump_pc", 64'(PC), 64'h4);
    check_val("bjump_flush", 64'(FLUSH), 64'h1);
    check_val("bjump_cnt", 64'(TAKEN_COUNT), 64'h1);
    idle("bjump_after");
    check_val("bjump_flush_drop", 64'(FLUSH), 64'h0);

    // 3. conditional branches at 0x20 with OFFSET=3
    goto_pc(32'h20);
    cycle("beq_nt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    check_val("beq_nt_pc", 64'(PC), 64'h24);
    goto_pc(32'h20);
    cycle("beq_t", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03);
    check_val("beq_t_pc", 64'(PC), 64'h30);
    goto_pc(32'h20);
    cycle("bne_t", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
    check_val("bne_t_pc", 64'(PC), 64'h30);
    goto_pc(32'h20);
    cycle("jmp_prio", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03);
    check_val("jmp_prio_pc", 64'(PC), 64'h30);
    goto_pc(32'h20);
    cycle("beq_over_bne", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03);
    check_val("beq_over_bne_pc", 64'(PC), 64'h24);

    // 4. stall with a pending forward jump at 0x40
    goto_pc(32'h40);
    for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);
    check_val("stall_pc", 64'(PC), 64'h40);
    check_val("stall_flush", 64'(FLUSH), 64'h0);
    check_val("stall_cnt", 64'(TAKEN_COUNT), 64'h0);
    cycle("unstall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);
    check_val("unstall_pc", 64'(PC), 64'h240);
    check_val("unstall_cnt", 64'(TAKEN_COUNT), 64'h1);

    // FLUSH held across a stall that starts in REDIR, consumed on first free edge
    cycle("redir_stall0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle("redir_stall1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_val("redir_stall_flush", 64'(FLUSH), 64'h1);
    idle("redir_release");
    check_val("redir_release_flush", 64'(FLUSH), 64'h0);

    // back-to-back redirects keep FLUSH high
    cycle("b2b0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    cycle("b2b1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0);
    check_val("b2b_flush", 64'(FLUSH), 64'h1);

    // random mix through the model
    for (int i = 0; i < 60; i++)
      cycle("rand", 1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    // 6. reset mid-stall with a redirect pending (also from REDIR)
    cycle("pre_redir", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    cycle("mid_stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    cycle("rst_stall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    check_val("rst_stall_pc", 64'(PC), 64'h0);
    check_val("rst_stall_flush", 64'(FLUSH), 64'h0);
    check_val("rst_stall_cnt", 64'(TAKEN_COUNT), 64'h0);
    idle("post_rst");
    check_val("post_rst_pc", 64'(PC), 64'h4);
    check_val("post_rst_cnt", 64'(TAKEN_COUNT), 64'h0);

    // 5. wrap and saturation on the second instance
    cycle2(1'b1, 1'b0);
    check_val("wrap_reset_pc", 64'(pc2), 64'hFFFF_FFFC);
    check_val("wrap_reset_cnt", 64'(cnt2), 64'h0);
    cycle2(1'b0, 1'b0);
    check_val("wrap_pc", 64'(pc2), 64'h0);
    for (int i = 0; i < 5; i++) begin
      cycle2(1'b0, 1'b1);
      check_val("sat_cnt", 64'(cnt2), 64'(((i + 1) > 3) ? 3 : (i + 1)));
    end
    check_val("sat_flush", 64'(fl2), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
